// File: rtl/lock_key_ctrl.sv
// Serial key loader for a locked FSM: shifts in KEY_W key bits LSB first plus an
// even-parity bit, commits the key on good parity and holds the FSM in reset otherwise.
module lock_key_ctrl #(
  parameter int KEY_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             fsm_rst,
  output logic             key_loaded,
  output logic             key_err
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PAR  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [7:0]       IDLE_MAX = 8'(TIMEOUT - 1);
  localparam logic [KEY_W-1:0] KEY_ONE  = KEY_W'(1);

  logic [2:0]       state_r,    state_s;
  logic [CNT_W-1:0] bit_cnt_r,  bit_cnt_s;
  logic [7:0]       idle_cnt_r, idle_cnt_s;
  logic [KEY_W-1:0] shift_r,    shift_s;
  logic [KEY_W-1:0] key_r,      key_s;

  function automatic logic even_parity(input logic [KEY_W-1:0] data);
    return ^data;
  endfunction

  // Next-state and datapath update; key_start outranks any coincident bit.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    idle_cnt_s = idle_cnt_r;
    shift_s    = shift_r;
    key_s      = key_r;
    case (state_r)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (key_start) begin
          state_s    = ST_LOAD;
          bit_cnt_s  = '0;
          idle_cnt_s = 8'd0;
          shift_s    = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD, ST_PAR: begin
        if (key_start) begin
          state_s    = ST_LOAD;
          bit_cnt_s  = '0;
          idle_cnt_s = 8'd0;
          shift_s    = '0;
        end else if (key_bit_valid) begin
          idle_cnt_s = 8'd0;
          if (state_r == ST_LOAD) begin
            shift_s   = (shift_r & ~(KEY_ONE << bit_cnt_r)) | (KEY_W'(key_bit) << bit_cnt_r);
            bit_cnt_s = bit_cnt_r + CNT_ONE;
            if (bit_cnt_r == LAST_BIT) begin
              state_s = ST_PAR;
            end else begin
              state_s = ST_LOAD;
            end
          end else if (key_bit == even_parity(shift_r)) begin
            state_s = ST_RUN;
            key_s   = shift_r;
          end else begin
            state_s = ST_ERR;
            key_s   = '0;
          end
        end else if (idle_cnt_r == IDLE_MAX) begin
          state_s = ST_ERR;
          key_s   = '0;
        end else begin
          idle_cnt_s = idle_cnt_r + 8'd1;
        end
      end
      default: begin
        // Unreachable encodings fall into the safe error state.
        state_s = ST_ERR;
        key_s   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= '0;
      idle_cnt_r <= 8'd0;
      shift_r    <= '0;
      key_r      <= '0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      idle_cnt_r <= idle_cnt_s;
      shift_r    <= shift_s;
      key_r      <= key_s;
    end
  end

  assign key_ready  = (state_r == ST_LOAD) || (state_r == ST_PAR);
  assign fsm_rst    = (state_r != ST_RUN);
  assign key_loaded = (state_r == ST_RUN);
  assign key_err    = (state_r == ST_ERR);
  assign keyinput   = key_r;

endmodule

// File: tb/tb_lock_key_ctrl.sv
// Directed bench for lock_key_ctrl (KEY_W=8, TIMEOUT=16) with hand-computed expectations.
module tb_lock_key_ctrl;

  logic       clk;
  logic       rst;
  logic       key_start;
  logic       key_bit;
  logic       key_bit_valid;
  logic       key_ready;
  logic [7:0] keyinput;
  logic       fsm_rst;
  logic       key_loaded;
  logic       key_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  lock_key_ctrl #(.KEY_W(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_start    (key_start),
    .key_bit      (key_bit),
    .key_bit_valid(key_bit_valid),
    .key_ready    (key_ready),
    .keyinput     (keyinput),
    .fsm_rst      (fsm_rst),
    .key_loaded   (key_loaded),
    .key_err      (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic frst,
                         input logic ld, input logic er, input logic [7:0] key);
    chk({tag, ".key_ready"},  {31'd0, key_ready},  {31'd0, rdy});
    chk({tag, ".fsm_rst"},    {31'd0, fsm_rst},    {31'd0, frst});
    chk({tag, ".key_loaded"}, {31'd0, key_loaded}, {31'd0, ld});
    chk({tag, ".key_err"},    {31'd0, key_err},    {31'd0, er});
    chk({tag, ".keyinput"},   {24'd0, keyinput},   {24'd0, key});
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_bit       = b;
    key_bit_valid = 1'b1;
    tick();
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] k);
    for (int i = 0; i < 8; i++) send_bit(k[i]);
  endtask

  initial begin
    rst           = 1'b1;
    key_start     = 1'b0;
    key_bit       = 1'b0;
    key_bit_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (10) tick();
    chk_out("idle_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Bits offered while idle must be ignored.
    key_bit_valid = 1'b1;
    key_bit       = 1'b1;
    repeat (3) tick();
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
    chk_out("idle_ignore", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Good load of 0xA5 (four ones, parity 0).
    start();
    chk_out("load", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_key(8'hA5);
    chk_out("par_wait", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_bit(1'b0);
    chk_out("run_a5", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    send_bit(1'b1);
    chk_out("run_ignore", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);

    // Reload 0x3C, restarted by key_start coincident with bit 5.
    start();
    chk_out("reload", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    key_start     = 1'b1;
    key_bit_valid = 1'b1;
    key_bit       = 1'b1;
    tick();
    key_start     = 1'b0;
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
    chk_out("restart", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    send_key(8'h3C);
    chk_out("reload_par", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    send_bit(1'b0);
    chk_out("run_3c", 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);

    // Wrong parity on 0xA5 clears the committed key.
    start();
    send_key(8'hA5);
    send_bit(1'b1);
    chk_out("par_err", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (4) tick();
    chk_out("err_hold", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    start();
    chk_out("err_restart", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_key(8'hA5);
    send_bit(1'b0);
    chk_out("run_a5_again", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);

    // Timeout: three bits then idle; ERR only after the 16th idle cycle.
    start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (15) tick();
    chk_out("idle15", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    tick();
    chk_out("idle16", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

    // 0x07 has three ones, so the correct parity bit is 1.
    start();
    send_key(8'h07);
    send_bit(1'b1);
    chk_out("run_07", 1'b0, 1'b0, 1'b1, 1'b0, 8'h07);

    // Reset after four bits of a reload returns everything to reset values.
    start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk_out("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    start();
    send_key(8'h5A);
    send_bit(1'b0);
    chk_out("run_5a", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
